// File: rtl/ping_mod_pkg.sv
// ping_mod_pkg: shared FSM state, command field layout and the
// quarter-wave sine ROM generator for the ping_mod DDS burst source.
package ping_mod_pkg;

    localparam int LUT_AW_C   = 8;
    localparam int SAMPLE_W_C = 24;
    // ROM image width; sized for the default LUT geometry
    localparam int LUT_BITS_C = (2 ** LUT_AW_C) * SAMPLE_W_C;

    localparam int CMD_W       = 48;
    localparam int CMD_FTW_LSB = 0;
    localparam int CMD_FTW_W   = 32;
    localparam int CMD_N_LSB   = 32;
    localparam int CMD_N_W     = 16;

    localparam real PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef logic [LUT_BITS_C-1:0] lut_flat_t;

    // Entry j sits at bits [j*sw +: sw]. Samples are taken at the
    // bin centre (j+0.5), so every entry is strictly positive and
    // the quadrant negation never overflows.
    function automatic lut_flat_t gen_lut(input int aw, input int sw);
        lut_flat_t rom;
        real       amp;
        real       x;
        int        v;
        rom = '0;
        amp = real'((1 << (sw - 1)) - 1);
        for (int j = 0; j < (1 << aw); j++) begin
            x   = amp * $sin(2.0 * PI * (real'(j) + 0.5)
                         / real'(1 << (aw + 2)));
            v   = $rtoi(x + 0.5);
            rom = rom | (lut_flat_t'(v) << (j * sw));
        end
        return rom;
    endfunction

endpackage

// File: rtl/sine_lut.sv
// sine_lut: quarter-wave sine ROM with quadrant folding, two register
// stages (ROM read, then fold/negate), both gated by en_i.
//   clk_i, rst_i (async, active high), en_i : clock, reset, advance
//   phase_i : {quadrant[1:0], address[AW-1:0]} of the phase word
//   sine_o  : registered signed sample, SW bits
module sine_lut
    import ping_mod_pkg::*;
#(
    parameter int AW = LUT_AW_C,
    parameter int SW = SAMPLE_W_C
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [AW+1:0]        phase_i,
    output logic signed [SW-1:0] sine_o
);

    localparam lut_flat_t ROM = gen_lut(AW, SW);

    logic [AW-1:0] addr;
    logic [SW-1:0] mag_q;
    logic          neg_q;

    // odd quadrants run the quarter wave backwards
    assign addr = phase_i[AW] ? ~phase_i[AW-1:0] : phase_i[AW-1:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mag_q  <= '0;
            neg_q  <= 1'b0;
            sine_o <= '0;
        end else if (en_i) begin
            mag_q  <= ROM[int'(addr) * SW +: SW];
            neg_q  <= phase_i[AW+1];
            sine_o <= neg_q ? -$signed(mag_q) : $signed(mag_q);
        end
    end

endmodule

// File: rtl/ping_mod.sv
// ping_mod: accepts one {N, FTW} burst command and emits N DDS sine
// samples on an AXI-Stream master, tlast on the final sample.
//   s_axis_aclk / s_axis_areset : clock, async active-high reset
//   s_axis_t*  : command slave, tdata = {N[15:0], FTW[31:0]}
//   m_axis_t*  : sample master, tdata = {sample, 8'h00},
//                tuser[0] = first sample, tlast = last sample
// Build option PING_MOD_WINDOW_EN adds a trapezoidal envelope stage.
module ping_mod
    import ping_mod_pkg::*;
#(
    parameter int PHASE_W  = 32,
    parameter int LUT_AW   = LUT_AW_C,
    parameter int SAMPLE_W = SAMPLE_W_C
`ifdef PING_MOD_WINDOW_EN
    ,
    parameter int RAMP_LOG2 = 6
`endif
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_areset,
    input  logic [CMD_W-1:0] s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [1:0]       m_axis_tuser
);

`ifdef PING_MOD_WINDOW_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 3;
`endif

    localparam logic [CMD_N_W-1:0] N_ONE = CMD_N_W'(1);

    state_e               state_q;
    logic [PHASE_W-1:0]   acc_q;
    logic [PHASE_W-1:0]   ftw_q;
    logic [CMD_N_W-1:0]   idx_q;
    logic [CMD_N_W-1:0]   n_q;
    logic [CMD_N_W-1:0]   n_cmd;
    logic                 tready_q;

    // index 0 is the phase stage, DEPTH-1 drives the outputs
    logic [DEPTH-1:0]     vld_q;
    logic [DEPTH-1:0]     first_q;
    logic [DEPTH-1:0]     last_q;
    logic [LUT_AW+1:0]    ph_q;

    logic                 en;
    logic                 cmd_hs;
    logic                 out_hs;
    logic                 issue;
    logic                 issue_last;
    logic signed [SAMPLE_W-1:0] sine;
    logic signed [SAMPLE_W-1:0] sample;

    assign n_cmd      = s_axis_tdata[CMD_N_LSB +: CMD_N_W];
    assign en         = !vld_q[DEPTH-1] || m_axis_tready;
    assign cmd_hs     = s_axis_tvalid && tready_q;
    assign out_hs     = vld_q[DEPTH-1] && m_axis_tready;
    assign issue      = (state_q == RUN) && en;
    assign issue_last = (idx_q == (n_q - N_ONE));

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
            acc_q    <= '0;
            ftw_q    <= '0;
            idx_q    <= '0;
            n_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tready_q <= 1'b1;
                    if (cmd_hs) begin
                        ftw_q <= PHASE_W'(s_axis_tdata[CMD_FTW_LSB +: CMD_FTW_W]);
                        n_q   <= n_cmd;
                        acc_q <= '0;
                        idx_q <= '0;
                        // N=0 is swallowed without leaving IDLE
                        if (n_cmd != '0) begin
                            state_q  <= RUN;
                            tready_q <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (en) begin
                        acc_q <= acc_q + ftw_q;
                        idx_q <= idx_q + N_ONE;
                        if (issue_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // the last sample leaving means the pipe is empty
                    if (out_hs && last_q[DEPTH-1]) begin
                        state_q  <= IDLE;
                        tready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    tready_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            vld_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            ph_q    <= '0;
        end else if (en) begin
            vld_q   <= {vld_q[DEPTH-2:0], issue};
            first_q <= {first_q[DEPTH-2:0], issue && (idx_q == '0)};
            last_q  <= {last_q[DEPTH-2:0], issue && issue_last};
            ph_q    <= acc_q[PHASE_W-1 -: LUT_AW+2];
        end
    end

    sine_lut #(
        .AW (LUT_AW),
        .SW (SAMPLE_W)
    ) u_lut (
        .clk_i   (s_axis_aclk),
        .rst_i   (s_axis_areset),
        .en_i    (en),
        .phase_i (ph_q),
        .sine_o  (sine)
    );

`ifdef PING_MOD_WINDOW_EN
    localparam int P_W = SAMPLE_W + RAMP_LOG2 + 1;
    localparam logic [CMD_N_W:0] G_MAX = (CMD_N_W + 1)'(1) << RAMP_LOG2;
    localparam logic [CMD_N_W:0] G_ONE = (CMD_N_W + 1)'(1);

    logic [CMD_N_W:0]           rise;
    logic [CMD_N_W:0]           fall;
    logic [CMD_N_W:0]           g_d;
    logic [CMD_N_W:0]           g0_q;
    logic [CMD_N_W:0]           g1_q;
    logic [CMD_N_W:0]           g2_q;
    logic signed [P_W-1:0]      prod;
    logic signed [SAMPLE_W-1:0] win_q;

    // gain = min(i+1, N-i, 2^RAMP_LOG2), travels with its sample
    always_comb begin
        rise = {1'b0, idx_q} + G_ONE;
        fall = {1'b0, n_q} - {1'b0, idx_q};
        g_d  = G_MAX;
        if (rise < g_d) g_d = rise;
        if (fall < g_d) g_d = fall;
        prod = P_W'(sine) * P_W'($signed({1'b0, g2_q}));
    end

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            g0_q  <= '0;
            g1_q  <= '0;
            g2_q  <= '0;
            win_q <= '0;
        end else if (en) begin
            g0_q  <= g_d;
            g1_q  <= g0_q;
            g2_q  <= g1_q;
            win_q <= SAMPLE_W'(prod >>> RAMP_LOG2);
        end
    end

    assign sample = win_q;
`else
    assign sample = sine;
`endif

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = vld_q[DEPTH-1];
    assign m_axis_tlast  = last_q[DEPTH-1];
    assign m_axis_tuser  = {1'b0, first_q[DEPTH-1]};
    assign m_axis_tdata  = {sample, {(32 - SAMPLE_W){1'b0}}};

endmodule

// File: tb/tb_ping_mod.sv
// tb_ping_mod: directed tests for the ping_mod DDS burst generator,
// with a real-math sine reference for expected samples.
module tb_ping_mod;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [1:0]  m_tuser;

    int total = 0;
    int bad = 0;

`ifdef PING_MOD_WINDOW_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    ping_mod dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int lut_ref(input int j);
        real x;
        x = 8388607.0 * $sin(2.0 * 3.14159265358979323846
                             * (real'(j) + 0.5) / 1024.0);
        return int'($floor(x + 0.5));
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] ph,
                                             input int i, input int n);
        int s;
        int a;
        int g;
        logic [31:0] t;
        a = int'(ph[29:22]);
        case (ph[31:30])
            2'd0:    s = lut_ref(a);
            2'd1:    s = lut_ref(255 - a);
            2'd2:    s = -lut_ref(a);
            default: s = -lut_ref(255 - a);
        endcase
`ifdef PING_MOD_WINDOW_EN
        g = 64;
        if (i + 1 < g) g = i + 1;
        if (n - i < g) g = n - i;
        s = (s * g) >>> 6;
`else
        g = i + n;
        if (g < 0) s = 0;
`endif
        t = 32'(s) << 8;
        return t;
    endfunction

    task automatic send_cmd(input logic [31:0] ftw, input int n);
        int w;
        w = 0;
        s_tdata  = {16'(n), ftw};
        s_tvalid = 1'b1;
        while (!s_tready && w < 100) begin
            tick;
            w++;
        end
        if (!s_tready) begin
            total++;
            bad++;
            $display("FAIL cmd_accept_timeout n=%0d tready=%b", n, s_tready);
        end
        tick;
        s_tvalid = 1'b0;
    endtask

    // Receives samples until stop_at handshakes; checks data/flags
    // against the model and that a stalled beat stays put.
    task automatic collect(input logic [31:0] ftw, input int n,
                           input bit rnd, input int stop_at,
                           output int cyc);
        int cnt;
        bit held;
        logic [35:0] hold;
        logic [35:0] obs;
        logic [34:0] expv;
        cnt  = 0;
        held = 1'b0;
        hold = '0;
        cyc  = 0;
        while (cnt < stop_at && cyc < 4 * n + 50) begin
            obs = {m_tvalid, m_tdata, m_tuser, m_tlast};
            if (held) begin
                total++;
                if (obs !== hold) begin
                    bad++;
                    $display("FAIL stall_hold i=%0d got=%h want=%h",
                             cnt, obs, hold);
                end
            end
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (m_tvalid) begin
                if (m_tready) begin
                    expv = {exp_data(32'(cnt) * ftw, cnt, n), 1'b0,
                            cnt == 0, cnt == n - 1};
                    total++;
                    if (obs[34:0] !== expv) begin
                        bad++;
                        $display("FAIL sample i=%0d got=%h want=%h",
                                 cnt, obs[34:0], expv);
                    end
                    cnt++;
                end else begin
                    held = 1'b1;
                    hold = obs;
                end
            end
            tick;
            cyc++;
        end
        m_tready = 1'b1;
        if (cnt < stop_at) begin
            total++;
            bad++;
            $display("FAIL collect_timeout got=%0d want=%0d", cnt, stop_at);
        end else if (stop_at == n) begin
            total++;
            if ({s_tready, m_tvalid} !== 2'b10) begin
                bad++;
                $display("FAIL after_last tready/tvalid got=%b want=10",
                         {s_tready, m_tvalid});
            end
        end
    endtask

    task automatic test_reset;
        #2;
        total++;
        if ({s_tready, m_tvalid, m_tdata, m_tlast, m_tuser} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b_%b_%h_%b_%b want=0",
                     s_tready, m_tvalid, m_tdata, m_tlast, m_tuser);
        end
        tick;
        tick;
        rst = 1'b0;
        tick;
        for (int k = 0; k < 20; k++) begin
            total++;
            if ({s_tready, m_tvalid} !== 2'b10) begin
                bad++;
                $display("FAIL idle k=%0d tready/tvalid got=%b want=10",
                         k, {s_tready, m_tvalid});
            end
            tick;
        end
    endtask

    task automatic test_basic;
        int cyc;
        m_tready = 1'b1;
        send_cmd(32'h4000_0000, 4);
        for (int k = 0; k < LAT; k++) begin
            total++;
            if (m_tvalid !== 1'b0) begin
                bad++;
                $display("FAIL latency early k=%0d tvalid got=%b want=0",
                         k, m_tvalid);
            end
            tick;
        end
        total++;
        if (m_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL latency tvalid got=%b want=1", m_tvalid);
        end
        collect(32'h4000_0000, 4, 1'b0, 4, cyc);
        total++;
        if (cyc != 4) begin
            bad++;
            $display("FAIL basic_consecutive cycles got=%0d want=4", cyc);
        end
    endtask

    task automatic test_random_stall;
        int cyc;
        send_cmd(32'h1000_0000, 1000);
        collect(32'h1000_0000, 1000, 1'b1, 1000, cyc);
    endtask

    task automatic test_back_to_back;
        int cyc;
        int seen;
        m_tready = 1'b1;
        send_cmd(32'h4000_0000, 0);
        total++;
        if (s_tready !== 1'b1) begin
            bad++;
            $display("FAIL n0_tready got=%b want=1", s_tready);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (m_tvalid) seen++;
            tick;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL n0_output valid_cycles got=%0d want=0", seen);
        end
        send_cmd(32'h4000_0000, 1);
        collect(32'h4000_0000, 1, 1'b0, 1, cyc);
        send_cmd(32'h2000_0000, 3);
        collect(32'h2000_0000, 3, 1'b0, 3, cyc);
    endtask

    task automatic test_reset_mid;
        int cyc;
        m_tready = 1'b1;
        send_cmd(32'h1000_0000, 100);
        collect(32'h1000_0000, 100, 1'b0, 37, cyc);
        total++;
        if (m_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset tvalid got=%b want=1", m_tvalid);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({s_tready, m_tvalid, m_tdata, m_tlast, m_tuser} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%b_%b_%h_%b_%b want=0",
                     s_tready, m_tvalid, m_tdata, m_tlast, m_tuser);
        end
        #1 rst = 1'b0;
        tick;
        total++;
        if ({s_tready, m_tvalid} !== 2'b10) begin
            bad++;
            $display("FAIL post_reset tready/tvalid got=%b want=10",
                     {s_tready, m_tvalid});
        end
        send_cmd(32'h4000_0000, 2);
        collect(32'h4000_0000, 2, 1'b0, 2, cyc);
    endtask

`ifdef PING_MOD_WINDOW_EN
    task automatic test_window;
        int cyc;
        m_tready = 1'b1;
        send_cmd(32'h4000_0000, 200);
        collect(32'h4000_0000, 200, 1'b0, 200, cyc);
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_random_stall;
        test_back_to_back;
        test_reset_mid;
`ifdef PING_MOD_WINDOW_EN
        test_window;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ping_mod.md
# ping_mod

Transmit-side counterpart of `demod`. It accepts one burst command on an AXI-Stream slave and synthesizes a sine tone burst with a phase accumulator (DDS). Each sample is 24-bit signed and is emitted on an AXI-Stream master toward the I2S DAC transmitter of the sonar front end. One command produces exactly N output samples; the last one carries `tlast`.

## Interface
- `PHASE_W`, 32: phase accumulator width.
- `LUT_AW`, 8: quarter-wave LUT address width (256 entries).
- `SAMPLE_W`, 24: signed sample width.
- `RAMP_LOG2`, 6: window ramp length is 2^RAMP_LOG2 samples. Used only with the window feature.

- `s_axis_aclk`  in  1  single clock for the whole block.
- `s_axis_areset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  48  command: [31:0] FTW (phase increment per sample), [47:32] N (burst length in samples).
- `s_axis_tvalid`  in  1  command valid.
- `s_axis_tready`  out  1  command accepted when high with `tvalid`.
- `m_axis_tdata`  out  32  left-justified sample: {sample[23:0], 8'h00}.
- `m_axis_tvalid`  out  1  sample valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  high on sample N-1 of the burst.
- `m_axis_tuser`  out  2  [0] = first sample of the burst; [1] = 0 (reserved).

## Operation
- FSM states:
  - IDLE: `s_axis_tready`=1. On handshake, latch FTW and N, clear phase to 0, set sample index i=0. Go to RUN; if N=0, stay in IDLE.
  - RUN: issue one phase per pipeline advance. When i=N-1 is issued, go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the last sample has handshaken, then go to IDLE.
- `s_axis_tready` is high only in IDLE. Commands are never queued.
- Phase: sample i uses phase = i*FTW mod 2^PHASE_W. The first sample uses phase 0.
- Phase decode:
  - q = phase[PHASE_W-1:PHASE_W-2]; a = phase[PHASE_W-3 -: LUT_AW].
  - lut[j] = round((2^(SAMPLE_W-1)-1)*sin(2π(j+0.5)/2^(LUT_AW+2))).
  - q0 → lut[a]; q1 → lut[~a]; q2 → -lut[a]; q3 → -lut[~a].
  - Negation is exact because lut[j] > 0.
- Lower phase bits are truncated; there is no interpolation and no dither.
- `m_axis_tuser[0]`=1 on i=0 only. `m_axis_tlast`=1 on i=N-1 only. For N=1 both are set on the same sample.

## Timing
- Reset values:
  - `s_axis_tready`=0 while reset is asserted, then 1 in IDLE.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0.
  - FSM=IDLE; phase, i, FTW and N cleared.
- Pipeline: phase register → LUT read register → fold/negate register (→ window multiply register when enabled).
- Latency from command handshake to first `m_axis_tvalid`: 3 cycles, or 4 with the window enabled.
- Throughput is 1 sample/cycle while `m_axis_tready`=1.
- Stall: the global enable is `!m_axis_tvalid || m_axis_tready`. All pipeline stages freeze when it is low.
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tuser` hold stable.
- A new command can be accepted the cycle after the tlast handshake. No samples are lost or duplicated across bursts.
- N=0: accepted, produces no output, `s_axis_tready` stays 1.
- Reset mid-burst: all outputs are cleared immediately (asynchronous), the remaining samples are discarded, and no partial tlast is emitted.

## Configuration
- `PING_MOD_WINDOW_EN` defined:
  - Adds a trapezoidal envelope with gain g = min(i+1, N-i, 2^RAMP_LOG2).
  - sample = (sine*g) >>> RAMP_LOG2. The product width is SAMPLE_W+RAMP_LOG2+1; the shift truncates toward -inf.
  - Adds one pipeline stage, so latency is 4.
- `PING_MOD_WINDOW_EN` undefined:
  - Rectangular burst, sample = sine.
  - No multiplier, latency 3.

## Structure
- Package `ping_mod_pkg` holds:
  - the FSM state enum (IDLE, RUN, DRAIN);
  - localparams for the command field positions;
  - a function that generates the LUT contents from LUT_AW/SAMPLE_W, used for ROM init.
- Sub-module `sine_lut` holds the quarter-wave ROM plus quadrant folding. It has a registered read with enable: input phase top bits, output signed SAMPLE_W.

## Test plan
- Reset, then idle: `s_axis_tready`=1 and `m_axis_tvalid`=0 for 20 cycles.
- FTW=2^30, N=4, window off, `m_axis_tready`=1:
  - output is lut[0], lut[255], -lut[0], -lut[255] on consecutive cycles;
  - `tuser[0]` is set on the first sample only and tlast on the fourth only;
  - the first valid appears 3 cycles after the command handshake.
- FTW=2^28, N=1000, with `m_axis_tready` toggling randomly:
  - exactly 1000 handshakes, with data identical to the all-ready run;
  - data is held stable during every stall.
- N=0, then N=1 back-to-back:
  - the first command produces no output;
  - the second produces one sample, lut[0]<<8, with tuser[0]=1 and tlast=1.
- Assert reset at sample 37 of an N=100 burst: outputs read 0 the same cycle. A following N=2 burst starts at phase 0.
- With `PING_MOD_WINDOW_EN`, RAMP_LOG2=6, FTW=2^30, N=200:
  - sample 0 = lut[0]>>>6;
  - samples 63..136 are unscaled;
  - sample 199 = (-lut[255])>>>6.
